redwine_feat_assembler: RTL and testbench

REDWINE_FEAT_ASSEMBLER -- requirements
Module: redwine_feat_assembler

---
 rtl/redwine_pkg.sv | 20 ++
 rtl/redwine_feat_quant.sv | 39 +++
 rtl/redwine_feat_assembler.sv | 121 ++++++++++++
 tb/tb_redwine_feat_assembler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/redwine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : redwine_pkg
// Brief    : Shared constants and FSM state type for the redwine feature
//            assembler (feature count, quantized width, packed vector width).
// Revision : 1.0 - initial release
// ============================================================================
package redwine_pkg;

  localparam int NFEAT = 11;
  localparam int FW    = 4;
  localparam int OUT_W = NFEAT * FW;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/redwine_feat_quant.sv
`default_nettype none
// ============================================================================
// Module   : redwine_feat_quant
// Brief    : Combinational 8-bit to FW-bit feature quantizer.
//            FEAT_ROUND_SAT_EN defined   : round-half-up then saturate.
//            FEAT_ROUND_SAT_EN undefined : plain truncation to the top FW bits.
//            FW is expected to be in 1..7 for the rounding variant.
// Revision : 1.0 - initial release
// ============================================================================
module redwine_feat_quant #(
  parameter int FW = redwine_pkg::FW
) (
  input  logic [7:0]    raw_i,
  output logic [FW-1:0] q_o
);

`ifdef FEAT_ROUND_SAT_EN
  localparam int         SHIFT  = 8 - FW;
  localparam logic [8:0] C_HALF = 9'(1 << (SHIFT - 1));
  localparam logic [8:0] C_MAX  = 9'((1 << FW) - 1);

  logic [8:0] w_sum;
  logic [8:0] w_shr;

  // Add half an LSB on 9 bits so 0xF8 and above cannot wrap, then clamp.
  always_comb begin
    w_sum = {1'b0, raw_i} + C_HALF;
    w_shr = w_sum >> SHIFT;
    q_o   = (w_shr > C_MAX) ? C_MAX[FW-1:0] : w_shr[FW-1:0];
  end
`else
  // Keep only the most significant FW bits of the raw value.
  always_comb begin
    q_o = raw_i[7 -: FW];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/redwine_feat_assembler.sv
`default_nettype none
// ============================================================================
// Module   : redwine_feat_assembler
// Brief    : Collects NFEAT raw features from a valid/ready stream, quantizes
//            each to FW bits and presents the packed vector to the MLP stage.
//            Framing errors (early or missing in_last) drop the partial sample
//            and pulse err for one cycle.
//            Build option: FEAT_ROUND_SAT_EN selects round+saturate quantizing
//            (default build truncates).
// Revision : 1.0 - initial release
// ============================================================================
module redwine_feat_assembler
  import redwine_pkg::*;
#(
  parameter int NFEAT = redwine_pkg::NFEAT,
  parameter int FW    = redwine_pkg::FW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NFEAT*FW-1:0] out_data,
  output logic                err
);

  localparam int              CNT_W   = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NFEAT - 1);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NFEAT*FW-1:0]   data_q;
  logic [NFEAT*FW-1:0]   data_d;
  logic                  err_q;
  logic                  err_d;

  logic [FW-1:0]         w_feat;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_at_end;
  logic                  w_final_ok;
  logic                  w_frame_err;

  redwine_feat_quant #(
    .FW    (FW)
  ) u_quant (
    .raw_i (in_data),
    .q_o   (w_feat)
  );

  // Handshake qualifiers and framing classification of the current transfer.
  always_comb begin
    w_in_fire   = in_valid & in_ready;
    w_out_fire  = out_valid & out_ready;
    w_at_end    = (cnt_q == C_LAST);
    w_final_ok  = w_in_fire & in_last & w_at_end;
    w_frame_err = w_in_fire & (in_last ^ w_at_end);
  end

  // State register together with counter, packing register and err pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: fill up on a clean final feature, drain on output accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (w_final_ok) state_d = ST_FULL;
      ST_FULL:    if (w_out_fire) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Output decode straight from the state register, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = (state_q == ST_FULL);
    out_data  = data_q;
    err       = err_q;
  end

  // Feature counter: advance per accepted feature, wrap on final or framing error.
  always_comb begin
    cnt_d = cnt_q;
    if (w_in_fire) begin
      if (in_last || w_at_end) cnt_d = '0;
      else                     cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Packing register: drop the partial vector on error, else write the slot at cnt_q.
  always_comb begin
    data_d = data_q;
    err_d  = w_frame_err;
    if (w_frame_err) begin
      data_d = '0;
    end else if (w_in_fire) begin
      for (int i = 0; i < NFEAT; i++) begin
        if (cnt_q == CNT_W'(i)) data_d[i*FW +: FW] = w_feat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_redwine_feat_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_redwine_feat_assembler
// Brief    : Scoreboard bench for redwine_feat_assembler. Expected vectors are
//            queued by the stimulus; a negedge monitor pops and compares on
//            each output handshake. Honors FEAT_ROUND_SAT_EN for the
//            quantization vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_redwine_feat_assembler;

  localparam int NF = 11;
  localparam int W  = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [NF*W-1:0] out_data;
  logic          err;

  logic [NF*W-1:0] exp_q[$];
  int            tests;
  int            fails;
  int            err_seen;
  int            err_exp;
  logic          err_prev;

  redwine_feat_assembler #(
    .NFEAT     (NF),
    .FW        (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every output handshake against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_vec: unexpected vector %h, none expected", out_data);
        end else begin
          logic [NF*W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            fails++;
            $display("FAIL out_vec: got %h expected %h", out_data, e);
          end
        end
      end
      if (err) begin
        err_seen++;
        tests++;
        if (err_prev) begin
          fails++;
          $display("FAIL err_width: err high %0d consecutive cycles, expected 1", 2);
        end
      end
      err_prev = err;
    end else begin
      err_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one feature; called and returns at 1 time unit after a posedge.
  task automatic send(input logic [7:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Standard ramp sample 0x10..0xB0 quantizes to 1..B under both settings.
  task automatic ramp_sample();
    exp_q.push_back(44'hBA987654321);
    for (int i = 0; i < NF; i++) send(8'((i + 1) * 16), (i == NF - 1));
  endtask

  initial begin
    logic [NF*W-1:0] qexp;
    tests     = 0;
    fails     = 0;
    err_seen  = 0;
    err_exp   = 0;
    err_prev  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic ramp with 1-cycle latency and out_valid falling after transfer.
    ramp_sample();
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_data", 64'(out_data), 64'hBA987654321);
    @(posedge clk); #1;
    chk("valid_falls", 64'(out_valid), 64'd0);
    chk("ready_back", 64'(in_ready), 64'd1);

    // Backpressure: hold for 5 cycles while junk input is offered.
    out_ready = 1'b0;
    ramp_sample();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_data", 64'(out_data), 64'hBA987654321);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 64'(in_ready), 64'd1);

    // Early in_last on 4th feature.
    for (int i = 0; i < 3; i++) send(8'h55, 1'b0);
    send(8'h55, 1'b1);
    err_exp++;
    chk("early_err_hi", 64'(err), 64'd1);
    chk("early_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("early_err_lo", 64'(err), 64'd0);
    ramp_sample();
    @(posedge clk); #1;

    // Missing in_last on 11th feature.
    for (int i = 0; i < NF; i++) send(8'h77, 1'b0);
    err_exp++;
    chk("nolast_err_hi", 64'(err), 64'd1);
    chk("nolast_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("nolast_err_lo", 64'(err), 64'd0);
    ramp_sample();
    @(posedge clk); #1;

    // Quantization corners: 0xF8, 0x18, 0x08 then zeros.
`ifdef FEAT_ROUND_SAT_EN
    qexp = 44'h0000000012F;
`else
    qexp = 44'h0000000001F;
`endif
    exp_q.push_back(qexp);
    send(8'hF8, 1'b0);
    send(8'h18, 1'b0);
    send(8'h08, 1'b0);
    for (int i = 3; i < NF; i++) send(8'h00, (i == NF - 1));
    chk("quant_data", 64'(out_data), 64'(qexp));
    @(posedge clk); #1;

    // Reset in the middle of a sample.
    for (int i = 0; i < 6; i++) send(8'h90, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ramp_sample();
    repeat (3) @(posedge clk);
    #1;

    chk("err_count", 64'(err_seen), 64'(err_exp));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
